// File: rtl/uk101_sram_pkg.sv
// Shared types and widths for the UK101 SRAM arbiter: FSM states, grant encoding
// and the byte/word data widths.
package uk101_sram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_VID = 1'b1
    } grant_t;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

endpackage

// File: rtl/uk101_sram_arbiter_if.sv
// Bundle of CPU, video and SRAM-side signals around the arbiter. The requesters
// and the SRAM model use the master modport; the arbiter uses the slave modport.
interface uk101_sram_arbiter_if #(
    parameter int ADDR_W = 19
);
    import uk101_sram_pkg::*;

    logic                cpu_req;
    logic                cpu_we;
    logic [ADDR_W:0]     cpu_addr;
    logic [BYTE_W-1:0]   cpu_wdata;
    logic [BYTE_W-1:0]   cpu_rdata;
    logic                cpu_ack;

    logic                vid_req;
    logic [ADDR_W-1:0]   vid_addr;
    logic [WORD_W-1:0]   vid_rdata;
    logic                vid_ack;

    logic [ADDR_W-1:0]   sram_a;
    logic [WORD_W-1:0]   sram_d_out;
    logic                sram_d_oe;
    logic [WORD_W-1:0]   sram_d_in;
    logic                sram_wel;
    logic                sram_lbl;
    logic                sram_ubl;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, sram_d_in,
        input  cpu_rdata, cpu_ack, vid_rdata, vid_ack,
        input  sram_a, sram_d_out, sram_d_oe, sram_wel, sram_lbl, sram_ubl
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, sram_d_in,
        output cpu_rdata, cpu_ack, vid_rdata, vid_ack,
        output sram_a, sram_d_out, sram_d_oe, sram_wel, sram_lbl, sram_ubl
    );

endinterface

// File: rtl/uk101_sram_arbiter.sv
// Round-robin arbiter sharing one 16-bit async SRAM between a byte-wide CPU port
// and a word-wide video read port.
//   state   | meaning
//   IDLE    | sample requests, latch the winner's address/data
//   ACCESS  | WAIT_CYCLES+1 cycles with address and lane strobes stable
//   RECOVER | write only: WE released, address/data/strobes held one cycle
//   DONE    | one-cycle ack to the granted requester
module uk101_sram_arbiter
    import uk101_sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    uk101_sram_arbiter_if.slave   bus
);

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

    state_t     state, state_nxt;
    grant_t     grant, last_grant;
    logic [2:0] cnt;
    logic       lat_we;
    logic       lat_lane;
    logic       take_cpu;
    logic       take_vid;
    logic       last_access;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        take_cpu      = 1'b0;
        take_vid      = 1'b0;
        last_access   = (state == ACCESS) && (cnt == 3'd0);
        bus.cpu_ack   = 1'b0;
        bus.vid_ack   = 1'b0;
        bus.sram_wel  = 1'b1;
        bus.sram_lbl  = 1'b1;
        bus.sram_ubl  = 1'b1;
        bus.sram_d_oe = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the requester that was not served last wins.
                take_cpu = bus.cpu_req && (!bus.vid_req || last_grant == GNT_VID);
                take_vid = bus.vid_req && !take_cpu;
                if (take_cpu || take_vid) state_nxt = ACCESS;
            end
            ACCESS: begin
                bus.sram_wel  = !lat_we;
                bus.sram_lbl  = (grant == GNT_CPU) && lat_lane;
                bus.sram_ubl  = (grant == GNT_CPU) && !lat_lane;
                bus.sram_d_oe = lat_we;
                if (last_access) state_nxt = lat_we ? RECOVER : DONE;
            end
            RECOVER: begin
                bus.sram_lbl  = (grant == GNT_CPU) && lat_lane;
                bus.sram_ubl  = (grant == GNT_CPU) && !lat_lane;
                bus.sram_d_oe = lat_we;
                state_nxt     = DONE;
            end
            DONE: begin
                bus.cpu_ack = (grant == GNT_CPU);
                bus.vid_ack = (grant == GNT_VID);
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant          <= GNT_VID;
            last_grant     <= GNT_VID;
            cnt            <= 3'd0;
            lat_we         <= 1'b0;
            lat_lane       <= 1'b0;
            bus.sram_a     <= '0;
            bus.sram_d_out <= '0;
            bus.cpu_rdata  <= '0;
            bus.vid_rdata  <= '0;
        end else begin
            if (take_cpu || take_vid) begin
                grant      <= take_cpu ? GNT_CPU : GNT_VID;
                last_grant <= take_cpu ? GNT_CPU : GNT_VID;
                cnt        <= WAIT_INIT;
                lat_we     <= take_cpu && bus.cpu_we;
                lat_lane   <= take_cpu && bus.cpu_addr[0];
                bus.sram_a <= take_cpu ? bus.cpu_addr[ADDR_W:1] : bus.vid_addr;
                if (take_cpu && bus.cpu_we) bus.sram_d_out <= {2{bus.cpu_wdata}};
            end else if (state == ACCESS && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (last_access && !lat_we) begin
                if (grant == GNT_CPU)
                    bus.cpu_rdata <= lat_lane ? bus.sram_d_in[15:8] : bus.sram_d_in[7:0];
                else
                    bus.vid_rdata <= bus.sram_d_in;
            end
        end
    end

endmodule

// File: doc/uk101_sram_arbiter.md
UK101_SRAM_ARBITER -- requirements
Module: uk101_sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning extra SRAM access cycles beyond the first (range 0..7).
REQ-002 SHALL have parameter ADDR_W, default 19, meaning SRAM word-address width.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port cpu_req  in  1  CPU request, level, held until cpu_ack.
REQ-006 SHALL have port cpu_we  in  1  1=write, 0=read.
REQ-007 SHALL have port cpu_addr  in  ADDR_W+1  byte address; bit 0 selects lane.
REQ-008 SHALL have port cpu_wdata  in  8  write byte.
REQ-009 SHALL have port cpu_rdata  out  8  read byte, valid from cpu_ack, held until next CPU read.
REQ-010 SHALL have port cpu_ack  out  1  one-cycle completion pulse.
REQ-011 SHALL have port vid_req  in  1  video read request, level, held until vid_ack.
REQ-012 SHALL have port vid_addr  in  ADDR_W  word address.
REQ-013 SHALL have port vid_rdata  out  16  read word, valid from vid_ack, held until next video read.
REQ-014 SHALL have port vid_ack  out  1  one-cycle completion pulse.
REQ-015 SHALL have ports sram_a out ADDR_W; sram_d_out out 16; sram_d_oe out 1 (drive enable for top-level tristate); sram_d_in in 16; sram_wel, sram_lbl, sram_ubl out 1 each, active-low.

Function
REQ-016 SHALL implement states IDLE, ACCESS, RECOVER, DONE.
REQ-017 IDLE SHALL sample requests each cycle; on any request, latch address/we/wdata, record the grant, load the wait counter with WAIT_CYCLES, and enter ACCESS.
REQ-018 Arbitration SHALL be round-robin: with a single request pending, grant it; with both pending, grant the requester not granted last; last_grant resets to video, so the CPU wins the first tie.
REQ-019 ACCESS SHALL last exactly WAIT_CYCLES+1 cycles, with sram_a and lane strobes stable throughout.
REQ-020 CPU lane: cpu_addr[0]=0 asserts sram_lbl and uses bits [7:0]; cpu_addr[0]=1 asserts sram_ubl and uses bits [15:8]; the word address is cpu_addr[ADDR_W:1].
REQ-021 Video access SHALL assert both sram_lbl and sram_ubl.
REQ-022 A read SHALL capture sram_d_in on the last ACCESS cycle into the granted rdata register (CPU: the selected lane byte), then enter DONE.
REQ-023 A write SHALL drive cpu_wdata onto both halves of sram_d_out with sram_d_oe=1 in ACCESS and RECOVER, and hold sram_wel low for all ACCESS cycles.
REQ-024 RECOVER SHALL last one cycle with sram_wel high and address, data and strobes held, then enter DONE.
REQ-025 DONE SHALL pulse the granted ack for one cycle and return to IDLE; the other ack SHALL stay low.
REQ-026 Latency SHALL be WAIT_CYCLES+2 cycles for reads and WAIT_CYCLES+3 cycles for writes, from the IDLE sampling edge to the ack cycle.
REQ-027 Requests SHALL be sampled only in IDLE; a req still high in the IDLE cycle after ack SHALL start a new transaction.
REQ-028 In IDLE, sram_wel, sram_lbl and sram_ubl SHALL be 1, sram_d_oe SHALL be 0, and sram_a SHALL hold its last value.
REQ-029 Address and data inputs that change during a transaction SHALL NOT affect it.

Reset
REQ-030 Reset SHALL immediately force IDLE, with sram_wel, sram_lbl and sram_ubl =1 and sram_d_oe=0.
REQ-031 Reset SHALL also force sram_a, sram_d_out, cpu_rdata and vid_rdata to 0, both acks to 0, last_grant to video and the counter to 0.
REQ-032 Reset asserted mid-transaction SHALL abort it with no ack and no further write strobe.

Structure
REQ-033 Package uk101_sram_pkg SHALL hold the state enumeration, the grant encoding and the data-width constants (8, 16).
REQ-034 The block SHALL have no sub-module; the arbiter, counter and FSM are a single flat module.

Verification (WAIT_CYCLES=1)
REQ-035 CPU write 0x5A to byte address 0x00003 -> sram_a=0x00001, sram_ubl=0, sram_wel low 2 cycles, sram_d_out=0x5A5A; cpu_ack 4 cycles after sampling.
REQ-036 With SRAM model word 0x1234 at 0x00001, CPU reads 0x00002 -> cpu_rdata=0x34, and CPU reads 0x00003 -> 0x12; ack 3 cycles after sampling.
REQ-037 cpu_req and vid_req raised in the same cycle after reset -> CPU is granted first, video next; then both held continuously -> grants alternate, with no requester served twice in a row.
REQ-038 Video read of 0x7FFFF (word 0xBEEF) -> vid_rdata=0xBEEF, both lanes low, sram_wel=1 throughout.
REQ-039 Reset pulsed in the first ACCESS cycle of a write -> sram_wel=1 at once, no cpu_ack, and the SRAM word is unchanged after the model's write setup time.
REQ-040 cpu_addr and cpu_wdata toggled during ACCESS -> the write uses the latched values.
